imem_boot_loader: RTL

- Byte-stream program loader directly upstream of the riscv32i core's instruction memory.
- Receives a framed program image over a valid/ready byte interface and assembles little-endian 32-bit words.
- Writes those words into IMEM starting at word address 0.
- Holds the core in reset until the image is fully written and its checksum matches. Replaces file-based preloading for hardware bring-up.

---
 rtl/imem_boot_loader_if.sv | 22 ++
 rtl/imem_boot_loader.sv | 117 +++++++++++
 2 files changed

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and IMEM write port of the boot loader, bundled as one interface.
// in_valid/in_ready: a byte moves on any posedge where both are high; the source may not retract or change in_data while in_valid is high and in_ready is low.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Framed program loader: MAGIC, CNT_LO, CNT_HI, 4*N data bytes, CSUM (XOR of data).
// Writes little-endian words to IMEM from address 0 and holds the core until the image verifies.
module imem_boot_loader #(
    parameter int          ADDR_W = 10,
    parameter logic [7:0]  MAGIC  = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    imem_boot_loader_if.slave bus,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CNT_LO = 3'd1,
        CNT_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    localparam logic [16:0] CAP = 17'(2 ** ADDR_W);

    state_t          state;
    logic [7:0]      cnt_lo;
    logic [15:0]     count;
    logic [1:0]      byte_idx;
    logic [23:0]     word_buf;
    logic [7:0]      csum;

    logic            xfer;
    logic [16:0]     n_ext;
    logic [ADDR_W:0] wl_next;

    assign xfer      = bus.in_valid & bus.in_ready;
    assign n_ext     = {1'b0, bus.in_data, cnt_lo};
    assign wl_next   = words_loaded + 1'b1;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            bus.in_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            core_hold      <= 1'b1;
            load_done      <= 1'b0;
            load_error     <= 1'b0;
            words_loaded   <= '0;
            cnt_lo         <= '0;
            count          <= '0;
            byte_idx       <= '0;
            word_buf       <= '0;
            csum           <= '0;
        end else begin
            bus.imem_we <= 1'b0;
            case (state)
                IDLE: begin
                    bus.in_ready <= 1'b1;
                    if (xfer && bus.in_data == MAGIC) state <= CNT_LO;
                end
                CNT_LO: if (xfer) begin
                    cnt_lo <= bus.in_data;
                    state  <= CNT_HI;
                end
                CNT_HI: if (xfer) begin
                    count <= {bus.in_data, cnt_lo};
                    if (n_ext == 17'd0) begin
                        state <= CSUM;
                    end else if (n_ext > CAP) begin
                        state        <= ERROR;
                        load_error   <= 1'b1;
                        bus.in_ready <= 1'b0;
                    end else begin
                        state <= DATA;
                    end
                end
                DATA: if (xfer) begin
                    csum     <= csum ^ bus.in_data;
                    byte_idx <= byte_idx + 2'd1;
                    case (byte_idx)
                        2'd0: word_buf[7:0]   <= bus.in_data;
                        2'd1: word_buf[15:8]  <= bus.in_data;
                        2'd2: word_buf[23:16] <= bus.in_data;
                        default: begin
                            // Word complete: the write strobe and the counter land on the same edge.
                            bus.imem_we    <= 1'b1;
                            bus.imem_addr  <= words_loaded[ADDR_W-1:0];
                            bus.imem_wdata <= {bus.in_data, word_buf};
                            words_loaded   <= wl_next;
                            if (17'(wl_next) == {1'b0, count}) state <= CSUM;
                        end
                    endcase
                end
                CSUM: if (xfer) begin
                    bus.in_ready <= 1'b0;
                    if (bus.in_data == csum) begin
                        state     <= DONE;
                        core_hold <= 1'b0;
                        load_done <= 1'b1;
                    end else begin
                        state      <= ERROR;
                        load_error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
